// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and constants for the uart_tx arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int BYTE_W       = 8;
    localparam int CLKS_PER_BIT = 868;
    localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Producer-side and serializer-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_byte;
    logic [N_REQ-1:0]   ack;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               tx_wr;
    logic [7:0]         tx_byte;
    logic               tx_active;
    logic               tx_done;
    logic               timeout;

    modport slave (
        input  req, req_byte, tx_active, tx_done,
        output ack, grant_id, busy, tx_wr, tx_byte, timeout
    );

    modport master (
        output req, req_byte, tx_active, tx_done,
        input  ack, grant_id, busy, tx_wr, tx_byte, timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker, first request above i_ptr wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]  i_ptr,
    output logic      [ID_W-1:0]  o_sel,
    output logic                  o_valid
);

    // Pass 1 finds the lowest request overall (the wrap case); pass 2
    // overrides it with the lowest request strictly above the pointer.
    always_comb begin
        o_sel   = '0;
        o_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_sel   = ID_W'(k);
                o_valid = 1'b1;
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k] && (ID_W'(k) > i_ptr)) begin
                o_sel = ID_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one uart_tx among N_REQ byte producers.
//            Optional watchdog in WAIT_DONE: define UART_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_sel;
    logic                w_valid;
    logic                w_grant;
    logic                w_expire;
    logic [BYTE_W-1:0]   w_sel_byte;

    logic [N_REQ-1:0]    r_ack;
    logic [N_REQ-1:0]    w_ack_nxt;
    logic                r_tx_wr;
    logic                w_tx_wr_nxt;
    logic [BYTE_W-1:0]   r_tx_byte;
    logic [BYTE_W-1:0]   w_tx_byte_nxt;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     w_grant_id_nxt;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic                r_timeout;
    logic                w_busy;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_sel   (w_sel),
        .o_valid (w_valid)
    );

    assign w_grant = (r_state == IDLE) && w_valid;

    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_sel_byte = bus.req_byte[i*BYTE_W +: BYTE_W];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_seen_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_seen_active <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_wait_cnt    <= '0;
            r_seen_active <= 1'b0;
        end else if (r_state == WAIT_DONE) begin
            r_wait_cnt    <= r_wait_cnt + 16'd1;
            r_seen_active <= r_seen_active | bus.tx_active;
        end
    end

    // A serializer that never raised tx_active in the first four cycles
    // never started, so there is no point waiting out the full limit.
    assign w_expire = (r_state == WAIT_DONE) && !bus.tx_done &&
                      ((r_wait_cnt == 16'(TIMEOUT_CYCLES - 1)) ||
                       ((r_wait_cnt == 16'd3) && !r_seen_active && !bus.tx_active));
`else
    logic w_unused_tx_active;
    assign w_unused_tx_active = bus.tx_active;
    assign w_expire           = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // tx_done is only honoured in WAIT_DONE; in ISSUE and IDLE it is stale.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_valid) w_state_nxt = ISSUE;
            ISSUE:     w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.tx_done || w_expire) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ack_nxt      = '0;
        w_tx_byte_nxt  = r_tx_byte;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        w_tx_wr_nxt    = (r_state == ISSUE);
        w_busy         = (r_state != IDLE);
        if (w_grant) begin
            w_ack_nxt      = N_REQ'(1) << w_sel;
            w_tx_byte_nxt  = w_sel_byte;
            w_grant_id_nxt = w_sel;
            w_ptr_nxt      = w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack      <= '0;
            r_tx_wr    <= 1'b0;
            r_tx_byte  <= '0;
            r_grant_id <= '0;
            r_ptr      <= ID_W'(N_REQ - 1);
            r_timeout  <= 1'b0;
        end else begin
            r_ack      <= w_ack_nxt;
            r_tx_wr    <= w_tx_wr_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_timeout  <= w_expire;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.tx_wr    = r_tx_wr;
    assign bus.tx_byte  = r_tx_byte;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = w_busy;
    assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed bench for uart_tx_arbiter with a grant-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int TOUT  = 10000;
    localparam int FRAME = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus();

    uart_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- producers: one byte FIFO per requester ----------------
    logic [7:0] pq [N][32];
    int ph [N] = '{default: 0};
    int pt [N] = '{default: 0};

    task automatic push(input int i, input logic [7:0] b);
        pq[i][pt[i] % 32] = b;
        pt[i]++;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_byte = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rst_n) ph[i] = pt[i];
                else if (bus.ack[i] && ph[i] != pt[i]) ph[i]++;
                bus.req[i]            = (ph[i] != pt[i]);
                bus.req_byte[8*i +: 8] = pq[i][ph[i] % 32];
            end
        end
    end

    // ---------------- serializer stub ----------------
    bit   stub_hang = 1'b0;
    bit   stub_dead = 1'b0;
    logic stub_done = 1'b0;
    logic stub_act  = 1'b0;
    logic inj_done  = 1'b0;
    int   scnt      = 0;

    assign bus.tx_done   = stub_done | inj_done;
    assign bus.tx_active = stub_act;

    initial begin
        forever begin
            @(negedge clk);
            stub_done = 1'b0;
            if (!rst_n) scnt = 0;
            else if (bus.tx_wr && !stub_dead) scnt = FRAME;
            else if (scnt > 0 && !stub_hang) begin
                scnt--;
                if (scnt == 0) stub_done = 1'b1;
            end
            stub_act = (scnt > 0) && !stub_dead;
        end
    end

    // ---------------- grant-level model ----------------
    int         m_ptr, m_id, m_age;
    bit         m_srv, m_seen, m_to;
    logic [7:0] m_byte;

    task automatic model_step();
        bit found;
        m_to = 1'b0;
        if (!rst_n) begin
            m_ptr = N - 1; m_srv = 0; m_age = 0; m_byte = 8'h00; m_id = 0; m_seen = 0;
        end else if (!m_srv) begin
            if (bus.req != '0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!found && bus.req[c]) begin
                        m_id  = c;
                        found = 1;
                    end
                end
                m_byte = bus.req_byte[8*m_id +: 8];
                m_ptr  = m_id;
                m_srv  = 1;
                m_age  = 0;
                m_seen = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            m_seen = m_seen | bus.tx_active;
            if (bus.tx_done) m_srv = 0;
`ifdef UART_ARB_TIMEOUT_EN
            else if ((m_age - 1) == TOUT - 1 || ((m_age - 1) == 3 && !m_seen)) begin
                m_srv = 0;
                m_to  = 1;
            end
`endif
            else m_age++;
        end
    endtask

    int         glog_id [64];
    logic [7:0] glog_b  [64];
    int         gcnt = 0;
    int         tcnt = 0;

    initial begin
        logic [N-1:0] e_ack;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            e_ack = '0;
            if (m_srv && m_age == 0) e_ack[m_id] = 1'b1;
            check("ack",      bus.ack,      e_ack);
            check("tx_wr",    bus.tx_wr,    (m_srv && m_age == 1));
            check("busy",     bus.busy,     m_srv);
            check("grant_id", bus.grant_id, m_id);
            check("tx_byte",  bus.tx_byte,  m_byte);
            check("timeout",  bus.timeout,  m_to);
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i] && gcnt < 64) begin
                    glog_id[gcnt] = i;
                    glog_b[gcnt]  = bus.tx_byte;
                    gcnt++;
                end
            end
            if (bus.timeout) tcnt++;
        end
    end

    // ---------------- directed sequence ----------------
    task automatic wait_grants(input int n, input int budget);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (gcnt >= n) break;
            t++;
            if (t > budget) begin
                check("wait_grants_budget", gcnt, n);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy) break;
            t++;
            if (t > budget) begin
                check("wait_idle_budget", bus.busy, 0);
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_c [5];
        logic [7:0] exp_cb [5];
        exp_c  = '{0, 1, 2, 3, 0};
        exp_cb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack",      bus.ack,      0);
        check("rst_tx_wr",    bus.tx_wr,    0);
        check("rst_tx_byte",  bus.tx_byte,  0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_busy",     bus.busy,     0);
        check("rst_timeout",  bus.timeout,  0);
        rst_n = 1'b1;

        // single requester
        push(0, 8'hA5);
        wait_grants(1, 100);
        check("single_ack",  bus.ack,     4'b0001);
        check("single_byte", bus.tx_byte, 8'hA5);
        @(negedge clk);
        check("single_txwr", bus.tx_wr,   1);
        check("single_ack0", bus.ack,     0);
        wait_idle(200);

        // contention from reset: 0,1,2,3,0
        do_reset();
        push(0, 8'h10); push(0, 8'h14);
        push(1, 8'h11); push(2, 8'h12); push(3, 8'h13);
        wait_grants(6, 1000);
        wait_idle(200);
        for (int i = 0; i < 5; i++) begin
            check("cont_id",   glog_id[1+i], exp_c[i]);
            check("cont_byte", glog_b[1+i],  exp_cb[i]);
        end

        // pointer wrap after a grant to 2
        push(2, 8'h22);
        wait_grants(7, 100);
        wait_idle(200);
        push(0, 8'h30); push(1, 8'h31);
        wait_grants(9, 400);
        wait_idle(200);
        check("wrap_id0", glog_id[6], 2);
        check("wrap_id1", glog_id[7], 0);
        check("wrap_id2", glog_id[8], 1);

        // late request during requester 1's frame
        push(1, 8'h41); push(1, 8'h42);
        wait_grants(10, 100);
        repeat (5) @(negedge clk);
        check("late_busy", bus.busy, 1);
        push(3, 8'h43);
        wait_grants(12, 400);
        wait_idle(200);
        check("late_id0",  glog_id[10], 3);
        check("late_b0",   glog_b[10],  8'h43);
        check("late_id1",  glog_id[11], 1);
        check("late_b1",   glog_b[11],  8'h42);

        // stray tx_done in IDLE and in ISSUE must be ignored
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        push(2, 8'h55);
        wait_grants(13, 100);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check("stray_txwr", bus.tx_wr, 1);
        @(negedge clk);
        check("stray_busy", bus.busy, 1);
        wait_idle(200);
        check("stray_id", glog_id[12], 2);

        // asynchronous reset mid-frame
        push(0, 8'h66);
        wait_grants(14, 100);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_busy",    bus.busy,     0);
        check("mid_tx_wr",   bus.tx_wr,    0);
        check("mid_tx_byte", bus.tx_byte,  0);
        check("mid_grant",   bus.grant_id, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_no_ack", gcnt, 14);
        check("mid_idle",   bus.busy, 0);

`ifdef UART_ARB_TIMEOUT_EN
        stub_hang = 1'b1;
        push(1, 8'h77); push(2, 8'h78);
        wait_grants(16, TOUT + 500);
        wait_idle(TOUT + 500);
        stub_hang = 1'b0;
        check("to_full_cnt", tcnt, 2);
        check("to_id0", glog_id[14], 1);
        check("to_id1", glog_id[15], 2);
        stub_dead = 1'b1;
        push(3, 8'h79);
        wait_grants(17, 100);
        wait_idle(20);
        stub_dead = 1'b0;
        check("to_early_cnt", tcnt, 3);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
